// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional build macro used by instr_fetch: BRANCH_ZERO_COND_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_W_DEF      = 10;
    localparam int unsigned LUT_DEPTH_DEF = 64;
    localparam int unsigned CNT_W_DEF     = 16;

    localparam logic [8:0] DONE_CODE = 9'b011111111;
    localparam logic [8:0] NOP_CODE  = 9'h000;

endpackage

// File: rtl/jump_lut.sv
// Jump target table: register array with async clear, one sync write port
// and one combinational read port (a same-index write lands after the read).
module jump_lut
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = LUT_DEPTH_DEF,
    parameter int unsigned DW    = PC_W_DEF,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch/sequencing front end: PC, jump LUT, IDLE/RUN/HALT control, cycle counter.
// Define BRANCH_ZERO_COND_EN to qualify jumps with the ALU Zero flag.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned LUT_DEPTH = LUT_DEPTH_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Stall,
    input  logic [8:0]       InstrIn,
    input  logic             Jen,
    input  logic [7:0]       Jptr,
    input  logic             Zero,
    input  logic             DoneIn,
    input  logic             LutWe,
    input  logic [5:0]       LutAddr,
    input  logic [PC_W-1:0]  LutData,
    output logic [PC_W-1:0]  ProgCtr,
    output logic [8:0]       MachCode,
    output logic             Running,
    output logic             Halted,
    output logic [CNT_W-1:0] CycleCnt
);

    fetch_state_t     r_state, w_state_nxt;
    logic [PC_W-1:0]  r_pc, w_pc_nxt, w_lut_target;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_jump_taken;
    logic             w_unused;

`ifdef BRANCH_ZERO_COND_EN
    assign w_jump_taken = Jen & Zero;
    assign w_unused     = ^Jptr[7:6];
`else
    assign w_jump_taken = Jen;
    assign w_unused     = ^{Zero, Jptr[7:6]};
`endif

    jump_lut #(
        .DEPTH (LUT_DEPTH),
        .DW    (PC_W)
    ) u_jump_lut (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_we    (LutWe),
        .i_waddr (LutAddr),
        .i_wdata (LutData),
        .i_raddr (Jptr[5:0]),
        .o_rdata (w_lut_target)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE, HALT: begin
                if (Start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                // Counter runs on stalled cycles too; only PC/state freeze.
                if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                if (!Stall) begin
                    if (DoneIn) begin
                        w_state_nxt = HALT;
                    end else if (w_jump_taken) begin
                        w_pc_nxt = w_lut_target;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ProgCtr  = r_pc;
    assign CycleCnt = r_cnt;
    assign Running  = (r_state == RUN);
    assign Halted   = (r_state == HALT);
    assign MachCode = (r_state == RUN) ? InstrIn : NOP_CODE;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a behavioural model queues expected
// outputs as each cycle's stimulus is driven; they are compared after the edge.
module tb_instr_fetch;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct packed {
        logic [9:0]  pc;
        logic [15:0] cnt;
        logic        run;
        logic        halt;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        Stall = 1'b0;
    logic [8:0]  InstrIn;
    logic        Jen = 1'b0;
    logic [7:0]  Jptr = '0;
    logic        Zero = 1'b0;
    logic        DoneIn = 1'b0;
    logic        LutWe = 1'b0;
    logic [5:0]  LutAddr = '0;
    logic [9:0]  LutData = '0;
    logic [9:0]  ProgCtr;
    logic [8:0]  MachCode;
    logic        Running;
    logic        Halted;
    logic [15:0] CycleCnt;

    logic [8:0]  rom [1024];
    exp_t        sb_q [$];

    int          m_state;
    logic [9:0]  m_pc;
    logic [15:0] m_cnt;
    logic [9:0]  m_lut [64];

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    assign InstrIn = rom[ProgCtr];

    instr_fetch #(
        .PC_W      (10),
        .LUT_DEPTH (64),
        .CNT_W     (16)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Stall    (Stall),
        .InstrIn  (InstrIn),
        .Jen      (Jen),
        .Jptr     (Jptr),
        .Zero     (Zero),
        .DoneIn   (DoneIn),
        .LutWe    (LutWe),
        .LutAddr  (LutAddr),
        .LutData  (LutData),
        .ProgCtr  (ProgCtr),
        .MachCode (MachCode),
        .Running  (Running),
        .Halted   (Halted),
        .CycleCnt (CycleCnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = '0;
        m_cnt   = '0;
        for (int i = 0; i < 64; i++) m_lut[i] = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},   32'(ProgCtr),  32'h0);
        check({tag, "_cnt"},  32'(CycleCnt), 32'h0);
        check({tag, "_run"},  32'(Running),  32'h0);
        check({tag, "_halt"}, 32'(Halted),   32'h0);
        check({tag, "_mc"},   32'(MachCode), 32'h0);
    endtask

    // One clock cycle: drive inputs, predict, then compare after the edge.
    task automatic step(input logic st, input logic sl, input logic je, input logic ze,
                        input logic [7:0] jp, input logic dn, input logic we,
                        input logic [5:0] wa, input logic [9:0] wd);
        int          n_state;
        logic [9:0]  n_pc;
        logic [15:0] n_cnt;
        logic        taken;
        exp_t        e;
        @(negedge Clk);
        Start = st; Stall = sl; Jen = je; Zero = ze; Jptr = jp;
        DoneIn = dn; LutWe = we; LutAddr = wa; LutData = wd;
`ifdef BRANCH_ZERO_COND_EN
        taken = je && ze;
`else
        taken = je;
`endif
        n_state = m_state; n_pc = m_pc; n_cnt = m_cnt;
        if (m_state != M_RUN) begin
            if (st) begin
                n_state = M_RUN; n_pc = '0; n_cnt = '0;
            end
        end else begin
            n_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            if (!sl) begin
                if (dn)         n_state = M_HALT;
                else if (taken) n_pc = m_lut[jp[5:0]];
                else            n_pc = m_pc + 10'd1;
            end
        end
        if (we) m_lut[wa] = wd;
        m_state = n_state; m_pc = n_pc; m_cnt = n_cnt;
        sb_q.push_back('{pc: n_pc, cnt: n_cnt, run: (n_state == M_RUN), halt: (n_state == M_HALT)});
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("pc",   32'(ProgCtr),  32'(e.pc));
            check("cnt",  32'(CycleCnt), 32'(e.cnt));
            check("run",  32'(Running),  32'(e.run));
            check("halt", 32'(Halted),   32'(e.halt));
            check("mc",   32'(MachCode), e.run ? 32'(rom[e.pc]) : 32'h0);
        end
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 10'h000);
    endtask

    task automatic lut_write(input logic [5:0] a, input logic [9:0] d);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, a, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom);
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge Clk);
        Reset_n = 1'b1;

        lut_write(6'd5,  10'h120);
        lut_write(6'd2,  10'h010);
        lut_write(6'd10, 10'h3FE);

        // Start, then straight-line ALU ops.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 10'h000);
        for (int i = 0; i < 3; i++) idle_step();
        check("seq_pc3", 32'(ProgCtr), 32'h3);
        check("seq_cnt3", 32'(CycleCnt), 32'h3);

        // Jump through LUT[5].
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 6'd0, 10'h000);
        check("jump_tgt", 32'(ProgCtr), 32'h120);
        idle_step();
        check("jump_next", 32'(ProgCtr), 32'h121);

        // Done -> HALT, PC holds, then restart.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 10'h000);
        check("halt_flag", 32'(Halted), 32'h1);
        check("halt_pc", 32'(ProgCtr), 32'h121);
        idle_step();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 10'h000);
        check("restart_pc", 32'(ProgCtr), 32'h0);
        check("restart_cnt", 32'(CycleCnt), 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 10'h000);
        check("start_in_run", 32'(ProgCtr), 32'h1);
        for (int i = 0; i < 3; i++) idle_step();

        // Stall at PC 4 with Jen (and once DoneIn) asserted.
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 6'd0, 10'h000);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 6'd0, 10'h000);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 6'd0, 10'h000);
        check("stall_pc", 32'(ProgCtr), 32'h4);
        check("stall_cnt", 32'(CycleCnt), 32'h7);
        idle_step();
        check("unstall_pc", 32'(ProgCtr), 32'h5);

        // Same-cycle write/read of index 2; upper Jptr bits set.
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hC2, 1'b0, 1'b1, 6'd2, 10'h050);
        check("wr_rd_old", 32'(ProgCtr), 32'h010);
        idle_step();
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 6'd0, 10'h000);
        check("wr_rd_new", 32'(ProgCtr), 32'h050);

        // Jen with Zero low: outcome depends on build, model covers both.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 6'd0, 10'h000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 6'd0, 10'h000);
        check("wrap_pre", 32'(ProgCtr), 32'h3FE);
        idle_step();
        check("wrap_max", 32'(ProgCtr), 32'h3FF);
        idle_step();
        check("wrap_zero", 32'(ProgCtr), 32'h0);

        // Asynchronous reset in the middle of a cycle.
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midreset");
        @(negedge Clk);
        Reset_n = 1'b1;

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 10'h000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 6'd0, 10'h000);
        check("lut_cleared", 32'(ProgCtr), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 10'h000);
        idle_step();

        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
